multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter A_WIDTH, default 12, width of operand DataA.
REQ-002 Parameter B_WIDTH, default 12, width of operand DataB; Result width is A_WIDTH+B_WIDTH (24 at defaults).
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Aclr  input  1  reset, synchronous, active-high.
REQ-005 ClkEn  input  1  clock enable; high = pipeline advances, low = all pipeline registers hold.
REQ-006 DataA  input  A_WIDTH  multiplicand, two's-complement signed.
REQ-007 DataB  input  B_WIDTH  multiplier, two's-complement signed.
REQ-008 Result  output  A_WIDTH+B_WIDTH  registered signed product DataA*DataB.

Function
REQ-009 Result SHALL equal the full-precision signed product, with no truncation, rounding or saturation.
REQ-010 Latency SHALL be 2 enabled cycles: DataA/DataB are registered at edge N, and the product appears on Result after edge N+1 when ClkEn is high at both edges.
REQ-011 The pipeline SHALL consist of input registers (A_r, B_r) and an output register (Result); no other state.
REQ-012 With ClkEn low at an edge, every pipeline register SHALL keep its value; input changes during that edge are ignored.
REQ-013 Throughput SHALL be one new operand pair per enabled cycle; there is no handshake or valid signal.
REQ-014 Boundary: -2048 * -2048 SHALL give +4194304 (0x400000), the only product needing the top bit as magnitude; it SHALL not overflow.
REQ-015 Boundary: any operand 0 SHALL give Result 0; -1 * 1 SHALL give 0xFFFFFF.

Reset
REQ-016 Aclr high at a rising edge SHALL clear A_r, B_r and Result to 0, regardless of ClkEn (reset has priority).
REQ-017 Reset mid-operation SHALL discard all in-flight products; Result SHALL stay 0 until 2 enabled cycles after Aclr deasserts with new operands.
REQ-018 After reset, with operands held at 0, Result SHALL remain 0.

Configuration
REQ-019 Macro MULT_OUT_PIPE_EN: when defined, an extra output register stage SHALL be added after the product register, making latency 3 enabled cycles; this stage obeys the same ClkEn and reset rules.
REQ-020 Without MULT_OUT_PIPE_EN, latency SHALL be exactly 2 enabled cycles per REQ-010.

Structure
REQ-021 Package multiplier_pkg SHALL hold the default width constants (A_WIDTH_DEF=12, B_WIDTH_DEF=12) and the derived result width.
REQ-022 One sub-module, mult_core, SHALL hold the combinational signed A_WIDTH x B_WIDTH product; the top level holds only registers, enable and reset logic.

Verification
REQ-023 Reset then DataA=15, DataB=3, ClkEn=1 -> Result=45 two edges after the operands are applied.
REQ-024 Back-to-back inputs, one pair per cycle: (25,4) then (50,2) -> Result=100 then 100 on consecutive cycles, each 2 cycles after its input.
REQ-025 Signed corners: (-2048,-2048) -> 4194304; (-1,1) -> 0xFFFFFF (-1); (2047,-2048) -> -4192256.
REQ-026 ClkEn low for 3 cycles while the operands change -> Result and the in-flight product are frozen; after ClkEn rises, the held product emerges after the remaining pipeline edges.
REQ-027 Aclr pulsed for 1 cycle, with ClkEn low, while the pipeline holds nonzero data -> Result=0 at the next edge; the first post-reset product follows after 2 enabled cycles.
REQ-028 With MULT_OUT_PIPE_EN defined, repeat REQ-023 -> Result=45 exactly three edges after the operands are applied.

Source files
------------

// File: rtl/multiplier_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_pkg
//   Shared constants for the pipelined signed multiplier.
//   A_WIDTH_DEF / B_WIDTH_DEF : default operand widths.
//   R_WIDTH_DEF               : derived full-precision product width.
//   result_width()            : product width for arbitrary operand widths.
// -----------------------------------------------------------------------------
package multiplier_pkg;

  localparam int A_WIDTH_DEF = 12;
  localparam int B_WIDTH_DEF = 12;
  localparam int R_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF;

  // A signed a x b product never needs more than a+b bits.
  function automatic int result_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/mult_core.sv
// -----------------------------------------------------------------------------
// mult_core
//   Purely combinational full-precision two's-complement multiplier.
//   Ports:
//     a : input  [A_WIDTH-1:0]          signed multiplicand
//     b : input  [B_WIDTH-1:0]          signed multiplier
//     p : output [A_WIDTH+B_WIDTH-1:0]  signed product, no truncation
// -----------------------------------------------------------------------------
module mult_core
  import multiplier_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF
) (
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

  localparam int P_WIDTH = result_width(A_WIDTH, B_WIDTH);

  logic signed [P_WIDTH-1:0] a_ext;
  logic signed [P_WIDTH-1:0] b_ext;

  // Sign-extend both operands to the product width first; the low P_WIDTH
  // bits of that product are exactly the full-precision signed result.
  assign a_ext = P_WIDTH'(a);
  assign b_ext = P_WIDTH'(b);
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
//   Pipelined signed multiplier: input registers -> product register
//   (-> optional extra output register). One operand pair per enabled cycle.
//   Latency is 2 enabled cycles, or 3 when MULT_OUT_PIPE_EN is defined.
//   Ports:
//     Clock  : input                        rising-edge clock
//     Aclr   : input                        synchronous active-high clear,
//                                           overrides ClkEn
//     ClkEn  : input                        high = pipeline advances,
//                                           low = all registers hold
//     DataA  : input  [A_WIDTH-1:0]         signed multiplicand
//     DataB  : input  [B_WIDTH-1:0]         signed multiplier
//     Result : output [A_WIDTH+B_WIDTH-1:0] registered signed product
//   Configuration macro: MULT_OUT_PIPE_EN adds the extra output stage.
// -----------------------------------------------------------------------------
module multiplier
  import multiplier_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF
) (
  input  logic                              Clock,
  input  logic                              Aclr,
  input  logic                              ClkEn,
  input  logic signed [A_WIDTH-1:0]         DataA,
  input  logic signed [B_WIDTH-1:0]         DataB,
  output logic signed [A_WIDTH+B_WIDTH-1:0] Result
);

  localparam int R_WIDTH = result_width(A_WIDTH, B_WIDTH);

  logic signed [A_WIDTH-1:0] a_q,    a_d;
  logic signed [B_WIDTH-1:0] b_q,    b_d;
  logic signed [R_WIDTH-1:0] prod_q, prod_d;
  logic signed [R_WIDTH-1:0] prod_w;

  mult_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_mult_core (
    .a (a_q),
    .b (b_q),
    .p (prod_w)
  );

`ifdef MULT_OUT_PIPE_EN
  logic signed [R_WIDTH-1:0] out_q, out_d;
`endif

  // Next-state: every stage holds unless ClkEn is high.
  // NOTE: hold values are assigned first so every path drives every _d
  //       signal; a missing default here would infer a latch.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
`ifdef MULT_OUT_PIPE_EN
    out_d  = out_q;
`endif
    if (ClkEn) begin
      a_d    = DataA;
      b_d    = DataB;
      prod_d = prod_w;
`ifdef MULT_OUT_PIPE_EN
      out_d  = prod_q;
`endif
    end
  end

  // NOTE: reset is tested ahead of the _d values so a clear wins over a
  //       held ClkEn; non-blocking assignments keep all stages sampling
  //       their pre-edge inputs, which is what makes this a pipeline.
  always_ff @(posedge Clock) begin
    if (Aclr) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
`ifdef MULT_OUT_PIPE_EN
      out_q  <= '0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
`ifdef MULT_OUT_PIPE_EN
      out_q  <= out_d;
`endif
    end
  end

`ifdef MULT_OUT_PIPE_EN
  assign Result = out_q;
`else
  assign Result = prod_q;
`endif

endmodule

// File: tb/tb_multiplier.sv
// -----------------------------------------------------------------------------
// tb_multiplier
//   Self-checking bench for multiplier. The reference model treats the DUT
//   as a LAT-deep delay line of products that advances on enabled edges and
//   is zero-filled by Aclr. Build with MULT_OUT_PIPE_EN to check the
//   3-cycle variant.
// -----------------------------------------------------------------------------
module tb_multiplier;
  import multiplier_pkg::*;

  localparam int A_W = A_WIDTH_DEF;
  localparam int B_W = B_WIDTH_DEF;
  localparam int R_W = R_WIDTH_DEF;
`ifdef MULT_OUT_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                  Clock;
  logic                  Aclr;
  logic                  ClkEn;
  logic signed [A_W-1:0] DataA;
  logic signed [B_W-1:0] DataB;
  logic signed [R_W-1:0] Result;

  int vectors;
  int miscompares;

  // Model: pipe[0] is the newest stage, pipe[LAT-1] drives Result.
  logic signed [R_W-1:0] pipe [$];

  multiplier #(
    .A_WIDTH (A_W),
    .B_WIDTH (B_W)
  ) dut (
    .Clock  (Clock),
    .Aclr   (Aclr),
    .ClkEn  (ClkEn),
    .DataA  (DataA),
    .DataB  (DataB),
    .Result (Result)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic signed [R_W-1:0] model_out();
    return pipe[LAT-1];
  endfunction

  // Drive inputs at the falling edge, let one rising edge happen, update
  // the model, then return at the next falling edge for sampling.
  task automatic cycle(input logic signed [A_W-1:0] a,
                       input logic signed [B_W-1:0] b,
                       input logic en, input logic rst);
    int prod;
    DataA = a;
    DataB = b;
    ClkEn = en;
    Aclr  = rst;
    @(posedge Clock);
    prod = int'(a) * int'(b);
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end else if (en) begin
      pipe.push_front(R_W'(prod));
      void'(pipe.pop_back());
    end
    @(negedge Clock);
  endtask

  task automatic test_reset();
    cycle(12'sd5, 12'sd7, 1'b1, 1'b1);
    cycle(12'sd5, 12'sd7, 1'b0, 1'b1);
    vectors++;
    if (Result !== '0) begin
      miscompares++;
      $display("FAIL reset_clear: Result=%0d expected 0", Result);
    end
    // Operands held at zero after reset keep Result at zero.
    for (int i = 0; i < LAT + 2; i++) begin
      cycle('0, '0, 1'b1, 1'b0);
      vectors++;
      if (Result !== '0) begin
        miscompares++;
        $display("FAIL reset_zero_hold[%0d]: Result=%0d expected 0", i, Result);
      end
    end
  endtask

  task automatic test_basic();
    cycle(12'sd15, 12'sd3, 1'b1, 1'b0);
    for (int i = 1; i < LAT; i++) cycle('0, '0, 1'b1, 1'b0);
    vectors++;
    if (Result !== 24'sd45) begin
      miscompares++;
      $display("FAIL basic_15x3: Result=%0d expected 45", Result);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [R_W-1:0] seen [$];
    cycle(12'sd25, 12'sd4, 1'b1, 1'b0);
    cycle(12'sd50, 12'sd2, 1'b1, 1'b0);
    for (int i = 2; i < LAT + 2; i++) begin
      if (i >= LAT) seen.push_back(Result);
      cycle('0, '0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (seen[i] !== 24'sd100) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: Result=%0d expected 100", i, seen[i]);
      end
    end
  endtask

  task automatic test_corners();
    logic signed [A_W-1:0] ca [6];
    logic signed [B_W-1:0] cb [6];
    logic signed [R_W-1:0] ce [6];
    ca = '{-12'sd2048, -12'sd1, 12'sd2047, 12'sd0,   12'sd1234, -12'sd1};
    cb = '{-12'sd2048, 12'sd1,  -12'sd2048, -12'sd77, 12'sd0,   -12'sd1};
    ce = '{24'sd4194304, 24'shFFFFFF, -24'sd4192256, 24'sd0, 24'sd0, 24'sd1};
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 6) cycle(ca[i], cb[i], 1'b1, 1'b0);
      else       cycle('0, '0, 1'b1, 1'b0);
      if (i >= LAT - 1 && i - (LAT - 1) < 6) begin
        vectors++;
        if (Result !== ce[i-(LAT-1)]) begin
          miscompares++;
          $display("FAIL corner[%0d]: Result=%h expected %h",
                   i - (LAT - 1), Result, ce[i-(LAT-1)]);
        end
      end
    end
  endtask

  task automatic test_clken_hold();
    logic signed [R_W-1:0] frozen;
    cycle(12'sd100, -12'sd7, 1'b1, 1'b0);
    frozen = Result;
    for (int i = 0; i < 3; i++) begin
      cycle(A_W'($urandom), B_W'($urandom), 1'b0, 1'b0);
      vectors++;
      if (Result !== frozen) begin
        miscompares++;
        $display("FAIL clken_freeze[%0d]: Result=%0d expected %0d", i, Result, frozen);
      end
    end
    for (int i = 1; i < LAT; i++) cycle(12'sd3, 12'sd3, 1'b1, 1'b0);
    vectors++;
    if (Result !== -24'sd700) begin
      miscompares++;
      $display("FAIL clken_resume: Result=%0d expected -700", Result);
    end
  endtask

  task automatic test_reset_mid();
    cycle(12'sd123, 12'sd45, 1'b1, 1'b0);
    cycle(12'sd77, -12'sd3, 1'b1, 1'b0);
    cycle(12'sd11, 12'sd11, 1'b0, 1'b1);
    vectors++;
    if (Result !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: Result=%0d expected 0", Result);
    end
    cycle(12'sd9, 12'sd9, 1'b1, 1'b0);
    for (int i = 1; i < LAT; i++) begin
      vectors++;
      if (Result !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_flush[%0d]: Result=%0d expected 0", i, Result);
      end
      cycle('0, '0, 1'b1, 1'b0);
    end
    vectors++;
    if (Result !== 24'sd81) begin
      miscompares++;
      $display("FAIL reset_mid_first: Result=%0d expected 81", Result);
    end
  endtask

  task automatic test_random();
    logic en, rst;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
      cycle(A_W'($urandom), B_W'($urandom), en, rst);
      vectors++;
      if (Result !== model_out()) begin
        miscompares++;
        $display("FAIL random[%0d]: Result=%0d expected %0d", i, Result, model_out());
      end
    end
  endtask

  // Every directed test also cross-checks the model so the two agree.
  task automatic test_model_sync();
    vectors++;
    if (Result !== model_out()) begin
      miscompares++;
      $display("FAIL model_sync: Result=%0d expected %0d", Result, model_out());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < LAT; i++) pipe.push_back('0);
    Aclr  = 1'b1;
    ClkEn = 1'b0;
    DataA = '0;
    DataB = '0;
    @(negedge Clock);
    test_reset();
    test_model_sync();
    test_basic();
    test_model_sync();
    test_back_to_back();
    test_model_sync();
    test_corners();
    test_model_sync();
    test_clken_hold();
    test_model_sync();
    test_reset_mid();
    test_model_sync();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
